// File: rtl/nota_selector_pkg.sv
// Shared definitions for the note selector and the VGA drawer: note codes, FSM states, defaults.
// No logic beyond a pure priority-encode helper.
package nota_selector_pkg;

    typedef logic [2:0] nota_t;

    localparam nota_t NOTA_NINGUNA = 3'd0;
    localparam nota_t NOTA_1       = 3'd1;
    localparam nota_t NOTA_2       = 3'd2;
    localparam nota_t NOTA_3       = 3'd3;
    localparam nota_t NOTA_4       = 3'd4;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;  // 10 ms at 25 MHz
    localparam int HOLD_FRAMES_DEF     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } estado_t;

    // Lowest button index wins.
    function automatic nota_t prio_encode(input logic [3:0] deb);
        nota_t n;
        n = NOTA_NINGUNA;
        if (deb[3]) n = NOTA_4;
        if (deb[2]) n = NOTA_3;
        if (deb[1]) n = NOTA_2;
        if (deb[0]) n = NOTA_1;
        return n;
    endfunction

endpackage

// File: rtl/nota_selector_if.sv
// Button/vsync inputs and note outputs between the board glue (master) and nota_selector (slave).
// Plain wires; no handshake, the selector never stalls its source.
interface nota_selector_if;
    import nota_selector_pkg::*;

    logic [3:0] btn;
    logic       vsync;
    nota_t      activacionNota;
    logic       nota_evento;

    modport master (
        output btn,
        output vsync,
        input  activacionNota,
        input  nota_evento
    );

    modport slave (
        input  btn,
        input  vsync,
        output activacionNota,
        output nota_evento
    );

endinterface

// File: rtl/nota_selector_antirrebote.sv
// One button bit: 2-flop synchronizer then a stable-level counter debouncer.
// Latency 2 + DEBOUNCE_CYCLES dclk from a raw level change to btn_deb; never stalls.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = nota_selector_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic dclk,
    input  logic clr,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q,   deb_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it and restart the count.
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_deb = deb_q;

endmodule

// File: rtl/nota_selector.sv
// Debounced buttons -> priority note, shown/held for HOLD_FRAMES and updated only at frame start.
// Output changes one dclk after the vsync falling edge; no backpressure.
module nota_selector
    import nota_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_FRAMES     = HOLD_FRAMES_DEF
) (
    input  logic               dclk,
    input  logic               clr,
    nota_selector_if.slave     bus
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);

    logic [3:0] btn_deb;
    nota_t      req;
    logic       frame_tick;

    logic       vsync_d_q, vsync_d_d;
    estado_t    state_q,   state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    nota_t      nota_q,    nota_d;
    logic       evento_q,  evento_d;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .dclk    (dclk),
            .clr     (clr),
            .btn_raw (bus.btn[i]),
            .btn_deb (btn_deb[i])
        );
    end

    assign req        = prio_encode(btn_deb);
    assign vsync_d_d  = bus.vsync;
    assign frame_tick = vsync_d_q & ~bus.vsync;

    // State register
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            vsync_d_q  <= 1'b1;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            nota_q     <= NOTA_NINGUNA;
            evento_q   <= 1'b0;
        end else begin
            vsync_d_q  <= vsync_d_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            nota_q     <= nota_d;
            evento_q   <= evento_d;
        end
    end

    // Next-state logic: everything is frozen between frame ticks.
    always_comb begin
        state_d = state_q;
        if (frame_tick) begin
            if (req != NOTA_NINGUNA) begin
                state_d = ST_SHOW;
            end else begin
                unique case (state_q)
                    ST_SHOW: state_d = ST_HOLD;
                    ST_HOLD: if (hold_cnt_q == 4'd1) state_d = ST_IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Output / datapath logic
    always_comb begin
        nota_d     = nota_q;
        hold_cnt_d = hold_cnt_q;
        if (frame_tick) begin
            if (req != NOTA_NINGUNA) begin
                nota_d     = req;
                hold_cnt_d = HOLD_INIT;
            end else if (state_q == ST_HOLD) begin
                hold_cnt_d = hold_cnt_q - 4'd1;
                if (hold_cnt_q == 4'd1) nota_d = NOTA_NINGUNA;
            end
        end
        // Rewriting the same note is not an event.
        evento_d = (nota_d != nota_q);
    end

    assign bus.activacionNota = nota_q;
    assign bus.nota_evento    = evento_q;

endmodule

// File: tb/tb_nota_selector.sv
// Directed bench for nota_selector with short debounce/hold; note changes checked against a queue.
module tb_nota_selector;
    import nota_selector_pkg::*;

    logic dclk = 1'b0;
    logic clr  = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int n_evt = 0;
    int n_exp_evt = 0;
    logic evt_prev = 1'b0;
    nota_t exp_q[$];

    nota_selector_if bus();

    nota_selector #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_FRAMES    (2)
    ) dut (
        .dclk (dclk),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    // One short frame boundary: vsync low for a single cycle.
    task automatic tick();
        bus.vsync = 1'b0;
        cyc(1);
        bus.vsync = 1'b1;
        cyc(1);
    endtask

    task automatic expect_note(input nota_t n);
        exp_q.push_back(n);
        n_exp_evt++;
    endtask

    // Scoreboard: every nota_evento pulse must match the next expected note.
    always @(negedge dclk) begin
        if (!clr) begin
            if (bus.nota_evento) begin
                n_evt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_evento", int'(bus.activacionNota), -1);
                end else begin
                    check("evento_note", int'(bus.activacionNota), int'(exp_q.pop_front()));
                end
                if (evt_prev) check("evento_one_cycle", 1, 0);
            end
            evt_prev = bus.nota_evento;
        end else begin
            evt_prev = 1'b0;
        end
    end

    initial begin
        bus.btn   = 4'b0000;
        bus.vsync = 1'b1;
        cyc(3);
        check("reset_note", int'(bus.activacionNota), 0);
        check("reset_evento", int'(bus.nota_evento), 0);
        clr = 1'b0;
        cyc(2);

        // Short glitch on btn[2] must be filtered.
        bus.btn = 4'b0100;
        cyc(3);
        bus.btn = 4'b0000;
        cyc(10);
        tick();
        check("glitch_note", int'(bus.activacionNota), 0);
        check("glitch_no_evento", n_evt, 0);

        // btn0: not yet debounced at first tick, shown only at the tick after.
        bus.btn = 4'b0001;
        cyc(3);
        tick();
        check("pre_debounce_note", int'(bus.activacionNota), 0);
        cyc(10);
        check("mid_frame_no_change", int'(bus.activacionNota), 0);
        expect_note(NOTA_1);
        tick();
        check("btn0_note", int'(bus.activacionNota), 1);
        check("btn0_evento_done", int'(bus.nota_evento), 0);

        // Release: SHOW -> HOLD, then two HOLD ticks clear it.
        bus.btn = 4'b0000;
        cyc(10);
        tick();
        check("hold1_t1", int'(bus.activacionNota), 1);
        tick();
        check("hold1_t2", int'(bus.activacionNota), 1);
        expect_note(NOTA_NINGUNA);
        tick();
        check("hold1_t3", int'(bus.activacionNota), 0);

        // Priority: 0110 -> 2, then drop btn1 -> 3.
        bus.btn = 4'b0110;
        cyc(10);
        expect_note(NOTA_2);
        tick();
        check("prio_note", int'(bus.activacionNota), 2);
        bus.btn = 4'b0100;
        cyc(10);
        expect_note(NOTA_3);
        tick();
        check("replace_note", int'(bus.activacionNota), 3);
        tick();
        check("same_note_kept", int'(bus.activacionNota), 3);

        // Asynchronous clear with btn2 still held.
        clr = 1'b1;
        #1;
        check("clr_async_note", int'(bus.activacionNota), 0);
        check("clr_async_evento", int'(bus.nota_evento), 0);
        cyc(1);
        clr = 1'b0;
        cyc(2);
        tick();
        check("clr_requalify_wait", int'(bus.activacionNota), 0);
        cyc(10);
        expect_note(NOTA_3);
        tick();
        check("clr_requalified", int'(bus.activacionNota), 3);

        // Note 4 replaces 3, then release and hold for 2 frames.
        bus.btn = 4'b1000;
        cyc(10);
        expect_note(NOTA_4);
        tick();
        check("note4", int'(bus.activacionNota), 4);
        bus.btn = 4'b0000;
        cyc(10);
        tick();
        check("hold4_enter", int'(bus.activacionNota), 4);
        tick();
        check("hold4_first", int'(bus.activacionNota), 4);
        expect_note(NOTA_NINGUNA);
        tick();
        check("hold4_second", int'(bus.activacionNota), 0);

        // No frame ticks: state frozen even with a qualified button.
        bus.btn = 4'b0010;
        cyc(20);
        check("frozen_note", int'(bus.activacionNota), 0);
        expect_note(NOTA_2);
        tick();
        check("unfreeze_note", int'(bus.activacionNota), 2);

        cyc(3);
        check("queue_drained", exp_q.size(), 0);
        check("evento_count", n_evt, n_exp_evt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nota_selector.md
NOTA_SELECTOR -- requirements
Module: nota_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable dclk cycles before a button level is accepted (10 ms at 25 MHz).
REQ-002 Parameter HOLD_FRAMES, default 6: frames a note stays displayed after its button is released (range 1..15).
REQ-003 dclk  input  1  pixel clock, 25 MHz; all logic rises on it.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 btn  input  4  raw, asynchronous push buttons, active-high; btn[i] selects note i+1.
REQ-006 vsync  input  1  active-low vertical sync from the VGA drawer, synchronous to dclk.
REQ-007 activacionNota  output  3  registered note code to the VGA drawer: 0 = none, 1..4 = lit tube.
REQ-008 nota_evento  output  1  one-cycle pulse on every change of activacionNota.

Function
REQ-009 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each bit SHALL have an independent debounce counter, clog2(DEBOUNCE_CYCLES+1) bits wide; it clears whenever the synchronized bit equals the debounced bit, otherwise it increments.
REQ-011 The debounced bit SHALL take the synchronized value, and its counter SHALL clear, on the cycle the counter reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-012 req SHALL be the priority encode of the debounced vector: lowest index wins (bit0 -> 1, ..., bit3 -> 4); no bits set -> 0.
REQ-013 frame_tick SHALL be high for one cycle when vsync_d = 1 and vsync = 0 (vsync_d = vsync delayed one dclk).
REQ-014 activacionNota SHALL change only on the dclk edge at which frame_tick is high, so tubes never change mid-frame.
REQ-015 FSM states: IDLE (activacionNota = 0), SHOW (button held), HOLD (released, counting frames).
REQ-016 On frame_tick in any state with req != 0: activacionNota <= req, hold_cnt <= HOLD_FRAMES, next state SHOW.
REQ-017 On frame_tick in SHOW with req = 0: next state HOLD; activacionNota unchanged.
REQ-018 On frame_tick in HOLD with req = 0: hold_cnt decrements; when it reaches 0 on this tick, activacionNota <= 0 and next state IDLE.
REQ-019 On frame_tick in IDLE with req = 0: no change.
REQ-020 A different button pressed during SHOW or HOLD SHALL replace the note at the next frame_tick and restart the hold count.
REQ-021 Presses and releases shorter than DEBOUNCE_CYCLES SHALL have no effect.
REQ-022 nota_evento SHALL be high for the single cycle after the edge on which activacionNota takes a new value; it is never asserted when the value written equals the old value.
REQ-023 Without frame_tick, i.e. vsync held constant, the state SHALL be frozen.

Reset
REQ-024 While clr is high: activacionNota = 0, nota_evento = 0, state IDLE, hold_cnt = 0, debounced bits = 0, debounce counters = 0, synchronizers = 0, vsync_d = 1.
REQ-025 clr asserted mid-operation SHALL abort immediately; after release, a still-held button re-qualifies through the full debounce before showing.

Structure
REQ-026 The state encoding, the note codes NOTA_NINGUNA = 0 and NOTA_1..NOTA_4 = 1..4, and the default parameter values SHALL live in a shared package also used by the VGA drawer.
REQ-027 The per-bit synchronizer and debounce logic SHALL be one sub-module, antirrebote, instantiated four times; the encoder, FSM and hold counter stay at top level.

Verification (DEBOUNCE_CYCLES = 4, HOLD_FRAMES = 2, short frames)
REQ-028 Stimulus: btn = 0001 held 20 cycles. Response: activacionNota = 1 at the first frame_tick after debounce; nota_evento is a single one-cycle pulse.
REQ-029 Stimulus: btn[2] glitch of 3 cycles. Response: activacionNota stays 0; nota_evento never asserts.
REQ-030 Stimulus: btn = 0110. Response: activacionNota = 2 (priority). Then drop btn[1]: activacionNota = 3 at the next frame_tick.
REQ-031 Stimulus: note 4 shown, button released. Response: activacionNota stays 4 through exactly 2 further frame_ticks of HOLD, then 0 on the second one.
REQ-032 Stimulus: clr pulsed while activacionNota = 3 and btn[2] still held. Response: output goes to 0 asynchronously; 3 reappears only after the debounce delay plus the next frame_tick.
REQ-033 Stimulus: button qualifies mid-frame. Response: no activacionNota change before the vsync falling edge.
